integration_layer_sequencer: RTL and testbench

- Sequences the post-photonic integration stage across the layers of one inference.
- Holds a per-layer configuration table and drives the integration block's num_input_cycles, num_outputs, layer and s_metadata_tvalid.
- Gates upstream MAC data with a ready signal, counts integration outputs, and inserts a flush gap between layers so the integration accumulator state clears.
- Signals done or error to the host-side control logic.

---
 rtl/integration_layer_sequencer_if.sv | 44 ++++
 rtl/integration_layer_sequencer.sv | 231 +++++++++++++++++++++++
 tb/tb_integration_layer_sequencer.sv | 377 +++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/integration_layer_sequencer_if.sv
// Purpose : control/handshake bundle between host, upstream MAC stream,
//           integration block and the integration layer sequencer.
// Latency : none; this is wiring only.
// Backpressure: s_data_tready is the only stall signal. The slave (sequencer)
//           drives it and the master (host/upstream side) must honour it.
// Ports   : cfg_wr_* table write, start/num_layers run control,
//           s_data_tvalid/s_data_tready upstream gate, int_tvalid output strobe,
//           layer/num_input_cycles/num_outputs/metadata_tvalid to integration,
//           busy/done/error status.
interface integration_layer_sequencer_if #(
   parameter int CYCLE_COUNTER_BITWIDTH = 10,
   parameter int LOG2_MAX_LAYERS        = 3
);
   logic                              cfg_wr_en;
   logic [LOG2_MAX_LAYERS-1:0]        cfg_wr_addr;
   logic [CYCLE_COUNTER_BITWIDTH-1:0] cfg_wr_num_input_cycles;
   logic [CYCLE_COUNTER_BITWIDTH-1:0] cfg_wr_num_outputs;
   logic                              start;
   logic [LOG2_MAX_LAYERS:0]          num_layers;
   logic                              s_data_tvalid;
   logic                              s_data_tready;
   logic                              int_tvalid;
   logic [LOG2_MAX_LAYERS-1:0]        layer;
   logic [CYCLE_COUNTER_BITWIDTH-1:0] num_input_cycles;
   logic [CYCLE_COUNTER_BITWIDTH-1:0] num_outputs;
   logic                              metadata_tvalid;
   logic                              busy;
   logic                              done;
   logic                              error;

   modport master (
      output cfg_wr_en, cfg_wr_addr, cfg_wr_num_input_cycles, cfg_wr_num_outputs,
             start, num_layers, s_data_tvalid, int_tvalid,
      input  s_data_tready, layer, num_input_cycles, num_outputs,
             metadata_tvalid, busy, done, error
   );

   modport slave (
      input  cfg_wr_en, cfg_wr_addr, cfg_wr_num_input_cycles, cfg_wr_num_outputs,
             start, num_layers, s_data_tvalid, int_tvalid,
      output s_data_tready, layer, num_input_cycles, num_outputs,
             metadata_tvalid, busy, done, error
   );
endinterface

// File: rtl/integration_layer_sequencer.sv
// Purpose : walks a per-layer config table, gates upstream MAC beats, counts
//           integration outputs and inserts a flush gap between layers.
// Latency : start at cycle N -> LOAD at N+1 -> s_data_tready at N+2; the
//           inter-layer tready-low gap is at least FLUSH_CYCLES+1 cycles.
// Backpressure: s_data_tready is high only in RUN and is decoded from state,
//           so it never depends combinationally on any input.
// Ports   : clk, rst_n (synchronous, active-low) plus the slave side of
//           integration_layer_sequencer_if (config, run control, data gate,
//           integration drive, busy/done/error status).
module integration_layer_sequencer #(
   parameter int CYCLE_COUNTER_BITWIDTH = 10,
   parameter int LOG2_MAX_LAYERS        = 3,
   parameter int FLUSH_CYCLES           = 8,
   parameter int FLUSH_TIMEOUT          = 1023
) (
   input logic                          clk,
   input logic                          rst_n,
   integration_layer_sequencer_if.slave bus
);
   localparam int CW    = CYCLE_COUNTER_BITWIDTH;
   localparam int LW    = LOG2_MAX_LAYERS;
   localparam int DEPTH = 2 ** LW;
   localparam int BW    = 2 * CW;
   localparam int FW    = $clog2(FLUSH_TIMEOUT + 1);

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_LOAD  = 3'd1,
      S_RUN   = 3'd2,
      S_FLUSH = 3'd3,
      S_DONE  = 3'd4
   } state_t;

   state_t          r_state;
   state_t          w_state_nxt;

   logic [CW-1:0]   r_tbl_cycles  [DEPTH];
   logic [CW-1:0]   r_tbl_outputs [DEPTH];

   logic [LW-1:0]   r_layer;
   logic [LW:0]     r_num_layers;
   logic [CW-1:0]   r_num_input_cycles;
   logic [CW-1:0]   r_num_outputs;
   logic [BW-1:0]   r_beat_cnt;
   logic [CW-1:0]   r_out_cnt;
   logic [FW-1:0]   r_flush_cnt;
   logic            r_error;

   logic            w_busy;
   logic            w_tready;
   logic            w_num_layers_ok;
   logic [CW-1:0]   w_tbl_c;
   logic [CW-1:0]   w_tbl_o;
   logic            w_load_zero;
   logic [BW-1:0]   w_target;
   logic            w_beat;
   logic            w_last_beat;
   logic            w_int_cnt;
   logic            w_out_ovf;
   logic [CW-1:0]   w_out_cnt_nxt;
   logic            w_flush_ok;
   logic            w_flush_tmo;
   logic            w_is_last;
   logic            w_err_set;
   logic            w_err_clr;

   // ---------------------------------------------------------------- decode
   assign w_num_layers_ok = (bus.num_layers != '0) &&
                            (bus.num_layers <= (LW+1)'(DEPTH));
   assign w_tbl_c         = r_tbl_cycles[r_layer];
   assign w_tbl_o         = r_tbl_outputs[r_layer];
   assign w_load_zero     = (w_tbl_c == '0) || (w_tbl_o == '0);
   // Full-width product, so no layer can wrap the beat counter.
   assign w_target        = {{CW{1'b0}}, r_num_input_cycles} *
                            {{CW{1'b0}}, r_num_outputs};
   assign w_beat          = bus.s_data_tvalid && w_tready;
   assign w_last_beat     = w_beat && ((r_beat_cnt + BW'(1)) == w_target);
   assign w_int_cnt       = bus.int_tvalid &&
                            ((r_state == S_RUN) || (r_state == S_FLUSH));
   assign w_out_ovf       = w_int_cnt && (r_out_cnt == r_num_outputs);
   assign w_out_cnt_nxt   = r_out_cnt + (w_int_cnt ? CW'(1) : CW'(0));
   // An output arriving on the exit cycle is counted before the exit test.
   assign w_flush_ok      = (w_out_cnt_nxt == r_num_outputs) &&
                            (r_flush_cnt >= FW'(FLUSH_CYCLES));
   assign w_flush_tmo     = (r_flush_cnt == FW'(FLUSH_TIMEOUT));
   assign w_is_last       = ({1'b0, r_layer} == (r_num_layers - (LW+1)'(1)));

   // ------------------------------------------------------ state register
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   // ----------------------------------------------------------- next state
   always_comb begin
      w_state_nxt = r_state;
      w_err_set   = 1'b0;
      w_err_clr   = 1'b0;
      case (r_state)
         S_IDLE: begin
            if (bus.start) begin
               if (w_num_layers_ok) begin
                  w_err_clr   = 1'b1;
                  w_state_nxt = S_LOAD;
               end else begin
                  w_err_set   = 1'b1;
               end
            end
         end
         S_LOAD: begin
            if (w_load_zero) begin
               w_err_set   = 1'b1;
               w_state_nxt = S_IDLE;
            end else begin
               w_state_nxt = S_RUN;
            end
         end
         S_RUN: begin
            if (w_out_ovf) begin
               w_err_set   = 1'b1;
               w_state_nxt = S_IDLE;
            end else if (w_last_beat) begin
               w_state_nxt = S_FLUSH;
            end
         end
         S_FLUSH: begin
            if (w_out_ovf) begin
               w_err_set   = 1'b1;
               w_state_nxt = S_IDLE;
            end else if (w_flush_ok) begin
               w_state_nxt = w_is_last ? S_DONE : S_LOAD;
            end else if (w_flush_tmo) begin
               w_err_set   = 1'b1;
               w_state_nxt = S_IDLE;
            end
         end
         S_DONE:  w_state_nxt = S_IDLE;
         default: w_state_nxt = S_IDLE;
      endcase
   end

   // --------------------------------------------------------- output decode
   always_comb begin
      w_tready            = 1'b0;
      w_busy              = 1'b0;
      bus.metadata_tvalid = 1'b0;
      bus.done            = 1'b0;
      case (r_state)
         S_LOAD:  w_busy = 1'b1;
         S_RUN: begin
            w_tready            = 1'b1;
            w_busy              = 1'b1;
            bus.metadata_tvalid = 1'b1;
         end
         // metadata stays qualified so data still in the integration pipe lands
         S_FLUSH: begin
            w_busy              = 1'b1;
            bus.metadata_tvalid = 1'b1;
         end
         S_DONE:  bus.done = 1'b1;
         default: ;
      endcase
   end

   assign bus.s_data_tready    = w_tready;
   assign bus.busy             = w_busy;
   assign bus.error            = r_error;
   assign bus.layer            = r_layer;
   assign bus.num_input_cycles = r_num_input_cycles;
   assign bus.num_outputs      = r_num_outputs;

   // ------------------------------------------------ config table (no reset)
   always_ff @(posedge clk) begin
      if (bus.cfg_wr_en && !w_busy) begin
         r_tbl_cycles[bus.cfg_wr_addr]  <= bus.cfg_wr_num_input_cycles;
         r_tbl_outputs[bus.cfg_wr_addr] <= bus.cfg_wr_num_outputs;
      end
   end

   // ------------------------------------------------------------- datapath
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_layer            <= '0;
         r_num_layers       <= '0;
         r_num_input_cycles <= '0;
         r_num_outputs      <= '0;
         r_beat_cnt         <= '0;
         r_out_cnt          <= '0;
         r_flush_cnt        <= '0;
         r_error            <= 1'b0;
      end else begin
         if (w_err_set) begin
            r_error <= 1'b1;
         end else if (w_err_clr) begin
            r_error <= 1'b0;
         end
         case (r_state)
            S_IDLE: begin
               if (bus.start && w_num_layers_ok) begin
                  r_layer      <= '0;
                  r_num_layers <= bus.num_layers;
               end
            end
            S_LOAD: begin
               r_num_input_cycles <= w_tbl_c;
               r_num_outputs      <= w_tbl_o;
               r_beat_cnt         <= '0;
               r_out_cnt          <= '0;
               r_flush_cnt        <= '0;
            end
            S_RUN: begin
               if (w_beat) begin
                  r_beat_cnt <= r_beat_cnt + BW'(1);
               end
               r_out_cnt <= w_out_cnt_nxt;
            end
            S_FLUSH: begin
               r_flush_cnt <= r_flush_cnt + FW'(1);
               r_out_cnt   <= w_out_cnt_nxt;
               if (w_state_nxt == S_LOAD) begin
                  r_layer <= r_layer + LW'(1);
               end
            end
            default: ;
         endcase
      end
   end
endmodule

// File: tb/tb_integration_layer_sequencer.sv
// Purpose : scoreboard bench for integration_layer_sequencer; stimulus pushes
//           expected layer-end/done/error events, a monitor pops and compares.
// Latency : checks start->tready latency, inter-layer gap and flush timeout.
// Backpressure: upstream valid is continuous or toggling; integration outputs
//           follow every num_input_cycles accepted beats after a short delay.
module tb_integration_layer_sequencer;
   localparam int CW = 10;
   localparam int LW = 3;

   localparam int EV_LE   = 0;
   localparam int EV_DONE = 1;
   localparam int EV_ERR  = 2;

   typedef struct {
      int kind;
      int layer;
      int beats;
      int nic;
      int no;
   } ev_t;

   logic clk   = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   integration_layer_sequencer_if #(
      .CYCLE_COUNTER_BITWIDTH(CW),
      .LOG2_MAX_LAYERS(LW)
   ) bus ();

   integration_layer_sequencer #(
      .CYCLE_COUNTER_BITWIDTH(CW),
      .LOG2_MAX_LAYERS(LW),
      .FLUSH_CYCLES(8),
      .FLUSH_TIMEOUT(1023)
   ) dut (
      .clk(clk),
      .rst_n(rst_n),
      .bus(bus)
   );

   ev_t  sb[$];
   int   n_checks = 0;
   int   n_errors = 0;
   int   dmode    = 0;
   logic gen_en   = 1'b1;
   logic inj_req  = 1'b0;

   task automatic chk(input string name, input int act, input int exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   task automatic push(input int kind, input int layer, input int beats,
                       input int nic, input int no);
      ev_t e;
      e.kind = kind; e.layer = layer; e.beats = beats; e.nic = nic; e.no = no;
      sb.push_back(e);
   endtask

   // ------------------------------------------------ upstream valid driver
   initial begin
      forever begin
         @(posedge clk);
         #1;
         case (dmode)
            1:       bus.s_data_tvalid = 1'b1;
            2:       bus.s_data_tvalid = ~bus.s_data_tvalid;
            default: bus.s_data_tvalid = 1'b0;
         endcase
      end
   end

   // ------------------------------- integration model: one output per group
   int         grp  = 0;
   logic [2:0] pend = 3'b000;
   logic       fire = 1'b0;
   initial begin
      forever begin
         @(negedge clk);
         fire = 1'b0;
         if (!rst_n || !bus.busy) begin
            grp = 0;
         end else if (bus.s_data_tready && bus.s_data_tvalid) begin
            if (grp + 1 >= int'(bus.num_input_cycles)) begin
               grp  = 0;
               fire = gen_en;
            end else begin
               grp++;
            end
         end
         if (!rst_n) pend = 3'b000;
         else        pend = {pend[1:0], fire};
         @(posedge clk);
         #1;
         bus.int_tvalid = pend[2] | inj_req;
         inj_req        = 1'b0;
      end
   end

   // -------------------------------------------------------------- monitor
   logic prev_tready = 1'b0;
   logic prev_err    = 1'b0;
   logic in_gap      = 1'b0;
   int   beats       = 0;
   int   gap         = 0;

   task automatic pop_cmp(input int kind);
      ev_t e;
      if (sb.size() == 0) begin
         n_checks++;
         n_errors++;
         $display("FAIL unexpected_event: got kind %0d expected none", kind);
      end else begin
         e = sb.pop_front();
         chk("ev_kind", kind, e.kind);
         if (kind == EV_LE) begin
            chk("le_layer", int'(bus.layer), e.layer);
            chk("le_beats", beats, e.beats);
            chk("le_nic", int'(bus.num_input_cycles), e.nic);
            chk("le_no", int'(bus.num_outputs), e.no);
         end else if (kind == EV_DONE) begin
            chk("done_layer", int'(bus.layer), e.layer);
            chk("done_nic", int'(bus.num_input_cycles), e.nic);
            chk("done_no", int'(bus.num_outputs), e.no);
            chk("done_busy", int'(bus.busy), 0);
         end else begin
            chk("err_busy", int'(bus.busy), 0);
            chk("err_done", int'(bus.done), 0);
         end
      end
   endtask

   initial begin
      forever begin
         @(negedge clk);
         if (!rst_n) begin
            prev_tready = 1'b0;
            prev_err    = 1'b0;
            in_gap      = 1'b0;
            beats       = 0;
         end else begin
            if (bus.error && !prev_err) begin
               pop_cmp(EV_ERR);
               beats = 0;
            end else if (bus.done) begin
               pop_cmp(EV_DONE);
            end else if (prev_tready && !bus.s_data_tready) begin
               pop_cmp(EV_LE);
               beats = 0;
            end
            if (!prev_tready && bus.s_data_tready && in_gap) begin
               chk("layer_gap", gap, 10);
               in_gap = 1'b0;
            end
            if (prev_tready && !bus.s_data_tready) begin
               in_gap = 1'b1;
               gap    = 0;
            end
            if (in_gap && !bus.s_data_tready) gap++;
            if (!bus.busy) in_gap = 1'b0;
            if (bus.s_data_tready && bus.s_data_tvalid) beats++;
            prev_tready = bus.s_data_tready;
            prev_err    = bus.error;
         end
      end
   end

   // -------------------------------------------------------------- helpers
   task automatic wr(input int addr, input int c, input int o);
      @(posedge clk);
      #1;
      bus.cfg_wr_en               = 1'b1;
      bus.cfg_wr_addr             = LW'(addr);
      bus.cfg_wr_num_input_cycles = CW'(c);
      bus.cfg_wr_num_outputs      = CW'(o);
      @(posedge clk);
      #1;
      bus.cfg_wr_en = 1'b0;
   endtask

   task automatic start_run(input int nl);
      @(posedge clk);
      #1;
      bus.start      = 1'b1;
      bus.num_layers = (LW+1)'(nl);
      @(posedge clk);
      #1;
      bus.start = 1'b0;
   endtask

   task automatic wait_idle(input int limit, input string name);
      int k = 0;
      while (bus.busy && k < limit) begin
         @(negedge clk);
         k++;
      end
      chk({name, "_finish_in_budget"}, int'(bus.busy), 0);
      repeat (2) @(posedge clk);
   endtask

   task automatic wait_tready(input logic lvl, input int limit, input string name);
      int k = 0;
      @(negedge clk);
      while (bus.s_data_tready !== lvl && k < limit) begin
         @(negedge clk);
         k++;
      end
      chk({name, "_tready_in_budget"}, int'(bus.s_data_tready), int'(lvl));
   endtask

   task automatic chk_all_zero(input string name);
      chk({name, "_tready"}, int'(bus.s_data_tready), 0);
      chk({name, "_meta"}, int'(bus.metadata_tvalid), 0);
      chk({name, "_busy"}, int'(bus.busy), 0);
      chk({name, "_done"}, int'(bus.done), 0);
      chk({name, "_error"}, int'(bus.error), 0);
      chk({name, "_layer"}, int'(bus.layer), 0);
      chk({name, "_nic"}, int'(bus.num_input_cycles), 0);
      chk({name, "_no"}, int'(bus.num_outputs), 0);
   endtask

   // ------------------------------------------------------------- watchdog
   initial begin
      #500000;
      $display("FAIL watchdog: got no end expected end of stimulus");
      $fatal(1, "watchdog");
   end

   // ------------------------------------------------------------- stimulus
   initial begin
      int k;
      int seen;
      bus.cfg_wr_en               = 1'b0;
      bus.cfg_wr_addr             = '0;
      bus.cfg_wr_num_input_cycles = '0;
      bus.cfg_wr_num_outputs      = '0;
      bus.start                   = 1'b0;
      bus.num_layers              = '0;
      bus.s_data_tvalid           = 1'b0;
      bus.int_tvalid              = 1'b0;

      repeat (3) @(posedge clk);
      @(negedge clk);
      chk_all_zero("reset");
      @(posedge clk);
      #1;
      rst_n = 1'b1;

      // Two-layer run; the L0 write shares its cycle with start.
      wr(1, 2, 2);
      wr(0, 5, 5);
      push(EV_LE, 0, 12, 4, 3);
      push(EV_LE, 1, 4, 2, 2);
      push(EV_DONE, 1, 0, 2, 2);
      dmode = 1;
      @(posedge clk);
      #1;
      bus.cfg_wr_en               = 1'b1;
      bus.cfg_wr_addr             = LW'(0);
      bus.cfg_wr_num_input_cycles = CW'(4);
      bus.cfg_wr_num_outputs      = CW'(3);
      bus.start                   = 1'b1;
      bus.num_layers              = (LW+1)'(2);
      @(posedge clk);
      #1;
      bus.cfg_wr_en = 1'b0;
      bus.start     = 1'b0;
      @(negedge clk);
      chk("load_busy", int'(bus.busy), 1);
      chk("load_tready", int'(bus.s_data_tready), 0);
      @(negedge clk);
      chk("run_tready", int'(bus.s_data_tready), 1);
      chk("run_meta", int'(bus.metadata_tvalid), 1);
      chk("run_layer", int'(bus.layer), 0);
      wait_idle(300, "run1");
      chk("run1_error", int'(bus.error), 0);

      // Same run with toggling upstream valid.
      dmode = 2;
      push(EV_LE, 0, 12, 4, 3);
      push(EV_LE, 1, 4, 2, 2);
      push(EV_DONE, 1, 0, 2, 2);
      start_run(2);
      wait_idle(400, "run2");
      chk("run2_error", int'(bus.error), 0);

      // Out-of-range layer counts, then a valid start clears the error.
      dmode = 1;
      push(EV_ERR, 0, 0, 0, 0);
      start_run(0);
      @(negedge clk);
      chk("nl0_busy", int'(bus.busy), 0);
      chk("nl0_error", int'(bus.error), 1);
      start_run(9);
      @(negedge clk);
      chk("nl9_busy", int'(bus.busy), 0);
      chk("nl9_error", int'(bus.error), 1);
      push(EV_LE, 0, 12, 4, 3);
      push(EV_LE, 1, 4, 2, 2);
      push(EV_DONE, 1, 0, 2, 2);
      start_run(2);
      @(negedge clk);
      chk("restart_error_cleared", int'(bus.error), 0);
      wait_idle(300, "run3");

      // Withheld outputs: flush times out.
      gen_en = 1'b0;
      push(EV_LE, 0, 12, 4, 3);
      push(EV_ERR, 0, 0, 0, 0);
      start_run(2);
      wait_tready(1'b1, 20, "tmo_rise");
      wait_tready(1'b0, 100, "tmo_fall");
      k = 0;
      while (!bus.error && k < 1200) begin
         @(negedge clk);
         k++;
      end
      chk("timeout_cycles", k, 1024);
      chk("timeout_busy", int'(bus.busy), 0);
      chk("timeout_error", int'(bus.error), 1);
      gen_en = 1'b1;
      repeat (2) @(posedge clk);

      // Zero num_outputs entry: error from LOAD, tready never rises.
      wr(0, 3, 0);
      push(EV_ERR, 0, 0, 0, 0);
      start_run(1);
      seen = 0;
      repeat (6) begin
         @(negedge clk);
         if (bus.s_data_tready) seen = 1;
      end
      chk("zero_out_no_tready", seen, 0);
      chk("zero_out_error", int'(bus.error), 1);

      // Extra output on a 3-output layer during FLUSH.
      wr(0, 4, 3);
      push(EV_LE, 0, 12, 4, 3);
      push(EV_ERR, 0, 0, 0, 0);
      start_run(1);
      wait_tready(1'b1, 20, "ovf_rise");
      wait_tready(1'b0, 100, "ovf_fall");
      repeat (5) @(negedge clk);
      inj_req = 1'b1;
      wait_idle(50, "ovf");
      chk("ovf_error", int'(bus.error), 1);

      // Reset mid-RUN, with an ignored write while busy.
      wr(1, 2, 2);
      start_run(2);
      wait_tready(1'b1, 20, "rst_rise");
      wr(0, 7, 7);
      @(posedge clk);
      #1;
      rst_n = 1'b0;
      @(posedge clk);
      @(negedge clk);
      chk_all_zero("midrun_reset");
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      push(EV_LE, 0, 12, 4, 3);
      push(EV_DONE, 0, 0, 4, 3);
      start_run(1);
      wait_idle(200, "after_reset");
      chk("after_reset_error", int'(bus.error), 0);

      repeat (5) @(posedge clk);
      chk("scoreboard_empty", sb.size(), 0);
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end
endmodule
